// File: rtl/pipelined_addsub.sv
// Elastic add/subtract pipeline: STAGES register stages with valid/ready flow control,
// carry/no-borrow and signed-overflow flags, and a wrapping completed-transaction counter.
module pipelined_addsub #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     sum,
  output logic                 cout,
  output logic                 ovf,
  output logic [CNT_WIDTH-1:0] txn_count
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] res;
  logic             res_cout;
  logic             res_ovf;

  // Subtract is A + ~B + 1, so op doubles as the carry-in.
  always_comb begin
    b_eff    = op ? ~b : b;
    ext      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op};
    res      = ext[WIDTH-1:0];
    res_cout = ext[WIDTH];
    res_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] cout_q;
  logic [STAGES-1:0] ovf_q;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;

  // Stage k advances when the sink is ready or any later stage is empty; computed flat
  // from the valid bits so there is no self-referencing chain.
  always_comb begin
    adv  = '0;
    load = '0;
    for (int k = 0; k < STAGES; k++) begin
      adv[k] = out_ready;
      for (int j = k + 1; j < STAGES; j++) begin
        if (!v_q[j]) adv[k] = 1'b1;
      end
      load[k] = !v_q[k] || adv[k];
    end
  end

  assign in_ready = load[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      cout_q <= '0;
      ovf_q  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
      end
    end else begin
      if (load[0]) begin
        v_q[0] <= in_valid;
        if (in_valid) begin
          sum_q[0]  <= res;
          cout_q[0] <= res_cout;
          ovf_q[0]  <= res_ovf;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          v_q[k] <= v_q[k-1];
          // Payload only moves with valid data so outputs hold when the pipe drains.
          if (v_q[k-1]) begin
            sum_q[k]  <= sum_q[k-1];
            cout_q[k] <= cout_q[k-1];
            ovf_q[k]  <= ovf_q[k-1];
          end
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = cout_q[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign txn_count = cnt_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub (WIDTH=8, STAGES=2); a second instance with a 4-bit
// counter shares the stimulus to exercise counter wrap.
module tb_pipelined_addsub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  sum;
  logic        cout;
  logic        ovf;
  logic [15:0] txn_count;

  logic        in_ready4;
  logic        out_valid4;
  logic [7:0]  sum4;
  logic        cout4;
  logic        ovf4;
  logic [3:0]  txn_count4;

  int n_pass  = 0;
  int n_total = 0;

  pipelined_addsub #(
    .WIDTH    (8),
    .STAGES   (2),
    .CNT_WIDTH(16)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .txn_count(txn_count)
  );

  pipelined_addsub #(
    .WIDTH    (8),
    .STAGES   (2),
    .CNT_WIDTH(4)
  ) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready4),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid4),
    .out_ready(out_ready),
    .sum      (sum4),
    .cout     (cout4),
    .ovf      (ovf4),
    .txn_count(txn_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called #1 after a rising edge; returns with the result on the outputs.
  task automatic op1(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                     input logic top, input logic [7:0] esum, input logic ecout,
                     input logic eovf);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    op       = top;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_sum"}, 64'(sum), 64'(esum));
    chk({tag, "_cout"}, 64'(cout), 64'(ecout));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eovf));
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
  endtask

  // Streams i+i for i=1..n from an empty pipe; out_ready low for loop cycles lo..hi.
  task automatic run_stream(input string tag, input int n, input int lo, input int hi,
                            input int exp_cnt);
    int  sent;
    int  got;
    bit  acc;
    bit  con;
    sent     = 0;
    got      = 0;
    in_valid = 1'b1;
    a        = 8'd1;
    b        = 8'd1;
    op       = 1'b0;
    for (int cyc = 0; cyc < 60 && got < n; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= lo && cyc <= hi);
      #1;
      acc = in_valid && in_ready;
      con = out_valid && out_ready;
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(!((sent - got) == 2 && !out_ready)));
      if (got > 0) chk({tag, "_out_valid_run"}, 64'(out_valid), 64'(1));
      if (out_valid) chk({tag, "_sum"}, 64'(sum), 64'(2 * (got + 1)));
      @(posedge clk); #1;
      if (acc) sent++;
      if (con) got++;
      if (sent < n) begin
        in_valid = 1'b1;
        a        = 8'(sent + 1);
        b        = 8'(sent + 1);
      end else begin
        in_valid = 1'b0;
      end
    end
    chk({tag, "_results"}, 64'(got), 64'(n));
    chk({tag, "_txn_count"}, 64'(txn_count), 64'(exp_cnt));
    chk({tag, "_drained"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    op        = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_txn_count", 64'(txn_count), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    op1("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op1("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op1("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    op1("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("directed_txn_count", 64'(txn_count), 64'(4));
    chk("directed_drained", 64'(out_valid), 64'(0));

    do_reset();
    run_stream("stream", 8, 100, 99, 8);

    do_reset();
    run_stream("stall", 8, 3, 7, 8);

    // Two ops in flight, then an asynchronous reset mid-cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 8'd3;
    b         = 8'd4;
    op        = 1'b0;
    @(posedge clk); #1;
    a = 8'd5;
    b = 8'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("inflight_out_valid", 64'(out_valid), 64'(1));
    chk("inflight_sum", 64'(sum), 64'(7));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    chk("async_rst_sum", 64'(sum), 64'(0));
    chk("async_rst_cout", 64'(cout), 64'(0));
    chk("async_rst_txn_count", 64'(txn_count), 64'(0));
    chk("async_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    op1("post_rst_add_50_50", 8'h50, 8'h50, 1'b0, 8'hA0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("post_rst_txn_count", 64'(txn_count), 64'(1));

    run_stream("wrap", 16, 100, 99, 17);
    chk("wrap_cnt4", 64'(txn_count4), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
